// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath (master) and
// the stall/flush controller (slave).
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       mem_branch;
  logic       mem_zero;
  logic       mem_jump;
  logic       mem_access;
  logic       dmem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       pc_redirect;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           mem_branch, mem_zero, mem_jump, mem_access, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           mem_branch, mem_zero, mem_jump, mem_access, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, MEM-stage redirects and
// bounded data-memory waits, with a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pipeline_hazard_ctrl_if.slave bus,
  output logic                  o_mem_err,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  typedef enum logic {StRun, StMemWait} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [WaitW-1:0] r_wait_cnt;
  logic [WaitW-1:0] w_wait_cnt_d;
  logic             r_mem_err;
  logic             w_mem_err_set;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_redirect;
  logic w_load_use;
  logic w_miss;
  logic w_freeze;

  assign w_redirect = bus.mem_jump | (bus.mem_branch & bus.mem_zero);
  assign w_load_use = bus.ex_memread & (bus.ex_rd != 5'd0) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
  assign w_miss     = bus.mem_access & ~bus.dmem_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StRun;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
      r_mem_err  <= r_mem_err | w_mem_err_set;
      if (!bus.pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d     = r_state;
    w_wait_cnt_d  = r_wait_cnt;
    w_mem_err_set = 1'b0;
    unique case (r_state)
      StRun: begin
        if (w_miss) begin
          w_state_d    = StMemWait;
          w_wait_cnt_d = WaitW'(1);
        end
      end
      StMemWait: begin
        if (bus.dmem_ready) begin
          w_state_d    = StRun;
          w_wait_cnt_d = '0;
        end else if (r_wait_cnt == TimeoutVal) begin
          w_state_d     = StRun;
          w_wait_cnt_d  = '0;
          w_mem_err_set = 1'b1;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 1'b1;
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  // Release cycles fall through to the RUN priority with miss masked off.
  assign w_freeze = (r_state == StRun) ? w_miss
                                       : (~bus.dmem_ready & (r_wait_cnt != TimeoutVal));

  // Output logic
  always_comb begin
    bus.pc_en        = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.id_ex_en     = 1'b1;
    bus.ex_mem_en    = 1'b1;
    bus.mem_wb_en    = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.pc_redirect  = 1'b0;
    if (i_rst || w_freeze) begin
      bus.pc_en     = 1'b0;
      bus.if_id_en  = 1'b0;
      bus.id_ex_en  = 1'b0;
      bus.ex_mem_en = 1'b0;
      bus.mem_wb_en = 1'b0;
    end else if (w_redirect) begin
      bus.pc_redirect  = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (w_load_use) begin
      bus.pc_en       = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

  assign o_mem_err   = r_mem_err;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl: a driver pushes the
// reference model's expected outputs, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 8;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [8:0]       ctl;  // pc,if_id,id_ex,ex_mem,mem_wb en; if_id,id_ex,ex_mem flush; redirect
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (hz.slave),
    .o_mem_err   (mem_err),
    .o_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state: is an access outstanding, how many cycles it has
  // been frozen so far, sticky error, stall count.
  bit m_waiting = 0;
  int m_frozen  = 0;
  bit m_err     = 0;
  int m_stalls  = 0;

  task automatic step(input bit r, input int rs1, input int rs2, input bit u1, input bit u2,
                      input bit mr, input int rd, input bit br, input bit z, input bit j,
                      input bit acc, input bit rdy);
    exp_t e;
    bit   redirect, lu, miss, freeze;
    @(posedge clk);
    #1;
    rst           = r;
    hz.id_rs1     = 5'(rs1);
    hz.id_rs2     = 5'(rs2);
    hz.id_use_rs1 = u1;
    hz.id_use_rs2 = u2;
    hz.ex_memread = mr;
    hz.ex_rd      = 5'(rd);
    hz.mem_branch = br;
    hz.mem_zero   = z;
    hz.mem_jump   = j;
    hz.mem_access = acc;
    hz.dmem_ready = rdy;

    e.err = m_err;
    e.cnt = CNT_W'(m_stalls);
    if (r) begin
      e.ctl     = 9'b0;
      m_waiting = 0;
      m_frozen  = 0;
      m_err     = 0;
      m_stalls  = 0;
    end else begin
      redirect = j || (br && z);
      lu       = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      miss     = acc && !rdy;
      freeze   = 0;
      if (!m_waiting) begin
        if (miss) begin
          freeze    = 1;
          m_waiting = 1;
          m_frozen  = 1;
        end
      end else if (rdy) begin
        m_waiting = 0;
      end else if (m_frozen == MEM_TIMEOUT) begin
        m_waiting = 0;
        m_err     = 1;
      end else begin
        freeze   = 1;
        m_frozen = m_frozen + 1;
      end
      if (freeze)        e.ctl = 9'b00000_000_0;
      else if (redirect) e.ctl = 9'b11111_111_1;
      else if (lu)       e.ctl = 9'b00111_010_0;
      else               e.ctl = 9'b11111_000_0;
      if (!e.ctl[8] && m_stalls < CNT_MAX) m_stalls = m_stalls + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit acc, input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc, rdy);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
             hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.pc_redirect};
      n_cmp = n_cmp + 3;
      if (act !== e.ctl) begin
        n_fail = n_fail + 1;
        $display("FAIL ctl @%0t: got %b want %b", $time, act, e.ctl);
      end
      if (mem_err !== e.err) begin
        n_fail = n_fail + 1;
        $display("FAIL mem_err @%0t: got %b want %b", $time, mem_err, e.err);
      end
      if (stall_cnt !== e.cnt) begin
        n_fail = n_fail + 1;
        $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
    hz.ex_memread = 0; hz.ex_rd = '0; hz.mem_branch = 0; hz.mem_zero = 0;
    hz.mem_jump = 0; hz.mem_access = 0; hz.dmem_ready = 0;

    // Reset with arbitrary inputs, then idle
    repeat (3) step(1, $urandom_range(0, 31), $urandom_range(0, 31), 1, 1, 1,
                    $urandom_range(0, 31), 1, 1, 1, 1, 0);
    idle(0, 0);
    // Load-use on rs2, then the same with ex_rd = 0
    step(0, 1, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0);
    idle(0, 0);
    step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    // Taken and not-taken branch, jump
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Memory wait: 3 low cycles then ready
    repeat (3) idle(1, 0);
    idle(1, 1);
    idle(0, 0);
    // Timeout: ready never asserted, then a new miss still stalls
    repeat (MEM_TIMEOUT + 1) idle(1, 0);
    repeat (2) idle(0, 0);
    repeat (2) idle(1, 0);
    idle(1, 1);
    // Miss + redirect + load-use together, released with redirect only
    step(0, 7, 0, 1, 0, 1, 7, 1, 1, 0, 1, 0);
    step(0, 7, 0, 1, 0, 1, 7, 1, 1, 0, 1, 1);
    // Reset during a wait abandons the access without mem_err
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle(1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(0, 0);
    repeat (3) idle(1, 0);
    idle(0, 1);

    // Randomized traffic; ready-likelihood changes per block to mix short
    // waits and timeouts
    for (int blk = 0; blk < 60; blk++) begin
      int thr;
      thr = $urandom_range(0, 3) * 3;
      for (int c = 0; c < 50; c++) begin
        step(($urandom_range(0, 299) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) < thr));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
